// File: rtl/text_pixel_gen_pkg.sv
// Shared constants and helpers for the character-cell text renderer.
// Font ROM address layout is {char[7:0], glyph_row[2:0], glyph_col[2:0]}.
package text_pkg;

   localparam int CHAR_W           = 8;
   localparam int CHAR_H           = 8;
   localparam int DEF_COLS         = 80;
   localparam int DEF_ROWS         = 60;
   localparam int DEF_BLINK_FRAMES = 32;
   localparam int DEF_TA_W         = 13;

   localparam int FONT_AD_W     = 14;
   localparam int FONT_CHAR_LSB = 6;
   localparam int FONT_ROW_LSB  = 3;
   localparam int FONT_COL_LSB  = 0;

   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
   } timing_t;

   localparam timing_t TIMING_RESET = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

   function automatic logic [FONT_AD_W-1:0] font_addr(input logic [7:0] ch,
                                                       input logic [2:0] row,
                                                       input logic [2:0] col);
      logic [FONT_AD_W-1:0] a;
      a = '0;
      a[FONT_CHAR_LSB +: 8] = ch;
      a[FONT_ROW_LSB  +: 3] = row;
      a[FONT_COL_LSB  +: 3] = col;
      return a;
   endfunction

endpackage

// File: rtl/text_pixel_gen_if.sv
// Memory-side bus of the text renderer: text RAM read port and font ROM port.
interface text_pixel_gen_if #(
   parameter int TA_W = 13
) ();

   logic [TA_W-1:0]                 tram_addr;
   logic [7:0]                      tram_data;
   logic [text_pkg::FONT_AD_W-1:0]  font_ad;
   logic                            font_ce;
   logic                            font_oce;
   logic                            font_reset;
   logic                            font_dout;

   modport master (
      output tram_addr, font_ad, font_ce, font_oce, font_reset,
      input  tram_data, font_dout
   );

   modport slave (
      input  tram_addr, font_ad, font_ce, font_oce, font_reset,
      output tram_data, font_dout
   );

endinterface

// File: rtl/text_pixel_gen_pipe_delay.sv
// Fixed-depth register delay line with a per-bit reset value.
module pipe_delay #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_r [DEPTH];

   // Shift the input through DEPTH registers; reset loads every stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RESET_VAL;
         end
      end else begin
         stage_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Character-cell text renderer: pixel coordinate -> text RAM -> font ROM -> pixel,
// with a blinking underline cursor and timing signals delayed to match (3 clocks).
module text_pixel_gen
   import text_pkg::*;
#(
   parameter int COLS         = DEF_COLS,
   parameter int ROWS         = DEF_ROWS,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
   parameter int TA_W         = DEF_TA_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [9:0]              x_in,
   input  logic [9:0]              y_in,
   input  logic                    active_in,
   input  logic                    hsync_in,
   input  logic                    vsync_in,
   input  logic                    cursor_en,
   input  logic [6:0]              cursor_col,
   input  logic [5:0]              cursor_row,
   text_pixel_gen_if.master        mem,
   output logic                    pixel,
   output logic                    active_out,
   output logic                    hsync_out,
   output logic                    vsync_out
);

   localparam int GCOL_W = $clog2(CHAR_W);
   localparam int GROW_W = $clog2(CHAR_H);
   localparam int FC_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [9-GCOL_W:0] ccol_s;
   logic [9-GROW_W:0] crow_s;
   logic [GCOL_W-1:0] gcol_s;
   logic [GROW_W-1:0] grow_s;
   logic              in_range_s;
   logic              cur_hit_s;
   logic [TA_W-1:0]   addr_s;

   logic [TA_W-1:0]   tram_addr_r;
   logic              in_range_r, in_range_d1_r, in_range_d2_r;
   logic              cur_hit_r, cur_hit_d1_r, cur_hit_d2_r;
   logic [GCOL_W-1:0] gcol_r, gcol_d1_r;
   logic [GROW_W-1:0] grow_r, grow_d1_r;

   logic              vsync_prev_r;
   logic [FC_W-1:0]   frame_cnt_r;
   logic              blink_phase_r;

   timing_t           timing_in_s;
   timing_t           timing_out_s;

   assign ccol_s = x_in[9:GCOL_W];
   assign crow_s = y_in[9:GROW_W];
   assign gcol_s = x_in[GCOL_W-1:0];
   assign grow_s = y_in[GROW_W-1:0];

   assign in_range_s = active_in & (int'(ccol_s) < COLS) & (int'(crow_s) < ROWS);
   assign addr_s     = TA_W'(crow_s) * TA_W'(COLS) + TA_W'(ccol_s);
   // Underline cursor sits on the bottom glyph row of the selected cell.
   assign cur_hit_s  = cursor_en & (ccol_s == cursor_col) & (crow_s == 7'(cursor_row))
                       & (grow_s == GROW_W'(CHAR_H - 1));

   // Stage 0: text RAM address and per-pixel attributes.
   always_ff @(posedge clk) begin
      if (reset) begin
         tram_addr_r <= '0;
         in_range_r  <= 1'b0;
         cur_hit_r   <= 1'b0;
         gcol_r      <= '0;
         grow_r      <= '0;
      end else begin
         tram_addr_r <= in_range_s ? addr_s : '0;
         in_range_r  <= in_range_s;
         cur_hit_r   <= cur_hit_s;
         gcol_r      <= gcol_s;
         grow_r      <= grow_s;
      end
   end

   // Stages 1 and 2: keep attributes aligned with the RAM and ROM read latencies.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_range_d1_r <= 1'b0;
         cur_hit_d1_r  <= 1'b0;
         gcol_d1_r     <= '0;
         grow_d1_r     <= '0;
         in_range_d2_r <= 1'b0;
         cur_hit_d2_r  <= 1'b0;
      end else begin
         in_range_d1_r <= in_range_r;
         cur_hit_d1_r  <= cur_hit_r;
         gcol_d1_r     <= gcol_r;
         grow_d1_r     <= grow_r;
         in_range_d2_r <= in_range_d1_r;
         cur_hit_d2_r  <= cur_hit_d1_r;
      end
   end

   // Blink timebase: count vsync falling edges, toggle phase every BLINK_FRAMES.
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_prev_r  <= 1'b1;
         frame_cnt_r   <= '0;
         blink_phase_r <= 1'b0;
      end else begin
         vsync_prev_r <= vsync_in;
         if (vsync_prev_r & ~vsync_in) begin
            if (frame_cnt_r == FC_W'(BLINK_FRAMES - 1)) begin
               frame_cnt_r   <= '0;
               blink_phase_r <= ~blink_phase_r;
            end else begin
               frame_cnt_r <= frame_cnt_r + FC_W'(1);
            end
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   assign mem.tram_addr  = tram_addr_r;
   assign mem.font_ad    = font_addr(mem.tram_data, grow_d1_r, gcol_d1_r);
   assign mem.font_ce    = 1'b1;
   assign mem.font_oce   = 1'b1;
   assign mem.font_reset = reset;

   // The ROM bit arrives straight from its output register, so the final AND is not re-registered.
   assign pixel = in_range_d2_r & (mem.font_dout | (cur_hit_d2_r & blink_phase_r));

   assign timing_in_s = {active_in, hsync_in, vsync_in};

   pipe_delay #(
      .WIDTH     (3),
      .DEPTH     (3),
      .RESET_VAL (TIMING_RESET)
   ) u_timing_delay (
      .clk   (clk),
      .reset (reset),
      .din   (timing_in_s),
      .dout  (timing_out_s)
   );

   assign active_out = timing_out_s.active;
   assign hsync_out  = timing_out_s.hsync;
   assign vsync_out  = timing_out_s.vsync;

endmodule

// File: tb/tb_text_pixel_gen.sv
// Directed bench for text_pixel_gen with a behavioural pixel model, external memory models
// and hand-computed literal expectations for the key scenarios.
module tb_text_pixel_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] x_in, y_in;
   logic       active_in, hsync_in, vsync_in, cursor_en;
   logic [6:0] cursor_col;
   logic [5:0] cursor_row;
   logic       pixel, active_out, hsync_out, vsync_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   text_pixel_gen_if #(.TA_W(13)) mem ();

   text_pixel_gen #(
      .COLS(80), .ROWS(60), .BLINK_FRAMES(32), .TA_W(13)
   ) dut (
      .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in),
      .active_in(active_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
      .mem(mem), .pixel(pixel), .active_out(active_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out)
   );

   logic [7:0] text_ram [0:8191];

   function automatic logic font_bit(input logic [13:0] a);
      logic [7:0] c;
      logic [7:0] bits;
      logic [2:0] r;
      c = a[13:6];
      r = a[5:3];
      if (c == 8'h41) begin
         case (r)
            3'd0:    bits = 8'h1C;
            3'd3:    bits = 8'h3E;
            3'd7:    bits = 8'h00;
            default: bits = 8'h22;
         endcase
      end else if (c == 8'h20) begin
         bits = 8'h00;
      end else begin
         bits = c ^ {r, r, r[1:0]};
      end
      return bits[a[2:0]];
   endfunction

   // External synchronous text RAM and font ROM
   always @(posedge clk) begin
      mem.tram_data <= text_ram[mem.tram_addr];
      mem.font_dout <= font_bit(mem.font_ad);
   end

   typedef struct packed {
      logic        inr;
      logic        fbit;
      logic        cur;
      logic        act;
      logic        hs;
      logic        vs;
      logic [12:0] addr;
      logic [13:0] fa;
      logic        fa_ok;
   } rec_t;

   localparam rec_t RST_REC = '{inr: 1'b0, fbit: 1'b0, cur: 1'b0, act: 1'b0, hs: 1'b1,
                                vs: 1'b1, addr: 13'd0, fa: 14'd0, fa_ok: 1'b0};

   function automatic rec_t make_rec(input int x, input int y, input logic a, input logic h,
                                     input logic v, input logic cen, input int ccur, input int rcur);
      rec_t r;
      int cc, cr, gc, gr;
      cc = x / 8;
      cr = y / 8;
      gc = x % 8;
      gr = y % 8;
      r.inr   = a && (cc < 80) && (cr < 60);
      r.addr  = r.inr ? 13'(cr * 80 + cc) : 13'd0;
      r.fa    = {text_ram[r.addr], 3'(gr), 3'(gc)};
      r.fbit  = font_bit(r.fa);
      r.cur   = cen && (cc == ccur) && (cr == rcur) && (gr == 7);
      r.act   = a;
      r.hs    = h;
      r.vs    = v;
      r.fa_ok = 1'b1;
      return r;
   endfunction

   rec_t s0, s1, s2;
   int   falls = 0;
   logic vprev = 1'b1;
   logic mvalid = 1'b0;

   // Reference model: three-deep record pipeline plus vsync falling-edge count
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         s0     <= RST_REC;
         s1     <= RST_REC;
         s2     <= RST_REC;
         falls  <= 0;
         vprev  <= 1'b1;
         mvalid <= 1'b1;
      end else begin
         s0 <= make_rec(int'(x_in), int'(y_in), active_in, hsync_in, vsync_in, cursor_en,
                        int'(cursor_col), int'(cursor_row));
         s1 <= s0;
         s2 <= s1;
         if (vprev && !vsync_in) falls <= falls + 1;
         vprev <= vsync_in;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   logic        log_pix [0:8191];
   logic        log_act [0:8191];
   logic        log_hs  [0:8191];
   logic        log_vs  [0:8191];
   logic [12:0] log_ta  [0:8191];
   logic [13:0] log_fa  [0:8191];

   // Per-cycle compare against the model, plus an output log for literal checks
   always @(negedge clk) begin
      logic phase;
      if (cyc < 8192) begin
         log_pix[cyc] = pixel;
         log_act[cyc] = active_out;
         log_hs[cyc]  = hsync_out;
         log_vs[cyc]  = vsync_out;
         log_ta[cyc]  = mem.tram_addr;
         log_fa[cyc]  = mem.font_ad;
      end
      if (mvalid) begin
         phase = ((falls / 32) % 2) == 1;
         chk("pixel",      pixel,      s2.inr & (s2.fbit | (s2.cur & phase)));
         chk("active_out", active_out, s2.act);
         chk("hsync_out",  hsync_out,  s2.hs);
         chk("vsync_out",  vsync_out,  s2.vs);
         chk("tram_addr",  mem.tram_addr, s0.addr);
         if (s1.fa_ok) chk("font_ad", mem.font_ad, s1.fa);
         chk("font_ce",  mem.font_ce,  1'b1);
         chk("font_oce", mem.font_oce, 1'b1);
      end
   end

   task automatic step(input int x, input int y, input logic a, input logic h, input logic v,
                       input logic r, output int c);
      @(negedge clk);
      c         = cyc;
      x_in      = 10'(x);
      y_in      = 10'(y);
      active_in = a;
      hsync_in  = h;
      vsync_in  = v;
      reset     = r;
   endtask

   task automatic idle(input int n);
      int c;
      repeat (n) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, c);
   endtask

   task automatic vsync_frames(input int n);
      int c;
      repeat (n) begin
         step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, c);
         step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, c);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         c, c0, c1, c2, cr;
      int         cs [12];
      logic [7:0] pat;
      logic [11:0] pa, ph, pv;

      pat = 8'b0001_1100;
      pa  = 12'b1011_0100_1110;
      ph  = 12'b1100_1110_0101;
      pv  = 12'b0111_1001_1011;

      for (int i = 0; i < 8192; i++) text_ram[i] = 8'(i * 7 + 3);
      text_ram[0]   = 8'h41;
      text_ram[245] = 8'h20;

      reset = 1'b1; x_in = '0; y_in = '0; active_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      cursor_en = 1'b0; cursor_col = 7'd0; cursor_row = 6'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pixel",      pixel,          1'b0);
      chk("rst_active_out", active_out,     1'b0);
      chk("rst_hsync_out",  hsync_out,      1'b1);
      chk("rst_vsync_out",  vsync_out,      1'b1);
      chk("rst_tram_addr",  mem.tram_addr,  13'd0);
      chk("rst_font_reset", mem.font_reset, 1'b1);
      idle(2);

      // Glyph 'A' top row at cell (0,0)
      for (int k = 0; k < 8; k++) begin
         step(k, 0, 1'b1, 1'b1, 1'b1, 1'b0, c);
         if (k == 0) c0 = c;
      end
      idle(4);
      for (int k = 0; k < 8; k++) begin
         chk("sweep_font_ad", log_fa[c0 + 2 + k], 14'h1040 + 14'(k));
         chk("sweep_pixel",   log_pix[c0 + 3 + k], pat[k]);
      end

      // Last valid cell and first out-of-range column
      step(632, 472, 1'b1, 1'b1, 1'b1, 1'b0, c1);
      step(640, 0,   1'b1, 1'b1, 1'b1, 1'b0, c2);
      idle(4);
      chk("corner_tram_addr", log_ta[c1 + 1], 13'd4799);
      chk("oor_tram_addr",    log_ta[c2 + 1], 13'd0);
      chk("oor_pixel",        log_pix[c2 + 3], 1'b0);
      chk("oor_active_out",   log_act[c2 + 3], 1'b1);

      // Cursor at (5,3) over a blank cell, phase on after 32 frames
      cursor_col = 7'd5; cursor_row = 6'd3; cursor_en = 1'b1;
      vsync_frames(32);
      for (int k = 0; k < 8; k++) begin
         step(40 + k, 31, 1'b1, 1'b1, 1'b1, 1'b0, c);
         cs[k] = c;
      end
      for (int k = 0; k < 8; k++) begin
         step(40 + k, 30, 1'b1, 1'b1, 1'b1, 1'b0, c);
         cs[k + 4 - 4] = cs[k];
         if (k == 0) c1 = c;
      end
      idle(4);
      for (int k = 0; k < 8; k++) begin
         chk("cursor_on_pixel",  log_pix[cs[k] + 3], 1'b1);
         chk("cursor_row30_pix", log_pix[c1 + k + 3], 1'b0);
      end
      vsync_frames(32);
      step(40, 31, 1'b1, 1'b1, 1'b1, 1'b0, c);
      step(44, 31, 1'b1, 1'b1, 1'b1, 1'b0, c2);
      idle(4);
      chk("cursor_off_pixel0", log_pix[c + 3],  1'b0);
      chk("cursor_off_pixel4", log_pix[c2 + 3], 1'b0);
      cursor_en = 1'b0;

      // Timing signal patterns
      for (int k = 0; k < 12; k++) begin
         step(100 + k, 100, pa[k], ph[k], pv[k], 1'b0, c);
         cs[k] = c;
      end
      idle(4);
      for (int k = 0; k < 12; k++) begin
         chk("delay_active", log_act[cs[k] + 3], pa[k]);
         chk("delay_hsync",  log_hs[cs[k] + 3],  ph[k]);
         chk("delay_vsync",  log_vs[cs[k] + 3],  pv[k]);
      end

      // Single-cycle reset in the middle of a line
      cursor_en = 1'b1;
      idle(2);
      if (falls % 32 == 0) vsync_frames(1);
      for (int k = 0; k < 8; k++) begin
         step(k, 0, 1'b1, 1'b0, 1'b1, (k == 3), c);
         if (k == 3) cr = c;
      end
      idle(5);
      chk("midrst_pixel",      log_pix[cr + 1], 1'b0);
      chk("midrst_active_out", log_act[cr + 1], 1'b0);
      chk("midrst_hsync_out",  log_hs[cr + 1],  1'b1);
      chk("midrst_vsync_out",  log_vs[cr + 1],  1'b1);
      chk("midrst_blank3",     log_act[cr + 3], 1'b0);
      chk("resume_pixel",      log_pix[cr + 4], 1'b1);
      chk("resume_active_out", log_act[cr + 4], 1'b1);
      chk("resume_hsync_out",  log_hs[cr + 4],  1'b0);

      // Frame counter restarted from zero by the reset
      vsync_frames(31);
      step(40, 31, 1'b1, 1'b1, 1'b1, 1'b0, c);
      idle(4);
      chk("post_rst_31_frames", log_pix[c + 3], 1'b0);
      vsync_frames(1);
      step(40, 31, 1'b1, 1'b1, 1'b1, 1'b0, c);
      idle(4);
      chk("post_rst_32_frames", log_pix[c + 3], 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
